z16_button_conditioner: RTL and testbench
=========================================

Name: z16_button_conditioner

Overview:
- Input conditioner that sits directly upstream of the Z16CPU `i_button` input.
- Synchronises the raw board push-button, debounces it, and produces a clean level, one-cycle press/release/long-press pulses, a sticky pending flag with CPU acknowledge, and a wrapping press counter.
- The CPU reads the clean level (or the pending/ack handshake) instead of the raw pin.

Parameters:
- SYNC_STAGES, 2: number of synchroniser flops, >=2.
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples required to accept a change, >=2.
- LONG_PRESS_CYCLES, 16: cycles after `o_press` at which `o_long` fires, >=1.
- COUNT_W, 8: width of the press counter.

Ports:
- i_clk  in  1  system clock, all logic on the rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_button  in  1  raw asynchronous button, active-high.
- i_ack  in  1  CPU acknowledge, clears `o_pending`.
- o_level  out  1  debounced button level.
- o_press  out  1  one-cycle pulse on accepted press.
- o_release  out  1  one-cycle pulse on accepted release.
- o_long  out  1  one-cycle pulse when held LONG_PRESS_CYCLES.
- o_hold  out  1  high from `o_long` until release.
- o_pending  out  1  sticky press flag.
- o_count  out  COUNT_W  number of accepted presses, mod 2^COUNT_W.

Behaviour:
- Reset (i_rst_n=0 at a rising edge):
  - synchroniser flops, FSM, all counters and all outputs go to 0; state returns to IDLE.
  - Applies mid-operation with no pending pulses emitted.
  - A button held through reset yields a fresh press after the normal latency.
- All outputs are registered. `s` denotes the last synchroniser stage.
- FSM states: IDLE, DEB_PRESS, PRESSED, DEB_RELEASE. One debounce counter, width clog2(DEBOUNCE_CYCLES)+1.
  - IDLE: s=1 -> DEB_PRESS, counter=1.
  - DEB_PRESS, s=0: back to IDLE, no outputs change (glitch rejected).
  - DEB_PRESS, s=1: counter+1. On reaching DEBOUNCE_CYCLES -> PRESSED, with o_level<=1, o_press<=1 for one cycle, o_count<=o_count+1 (wrap 2^COUNT_W-1 -> 0), o_pending<=1.
  - PRESSED: s=0 -> DEB_RELEASE, counter=1.
  - DEB_RELEASE, s=1: back to PRESSED; no o_release, no o_press, count unchanged.
  - DEB_RELEASE, s=0: on reaching DEBOUNCE_CYCLES -> IDLE, with o_level<=0, o_release<=1 for one cycle, o_hold<=0, hold counter cleared.
- Latency: counting the first edge that samples i_button=1 as edge 1, o_level/o_press rise at edge SYNC_STAGES+DEBOUNCE_CYCLES (6 with defaults). The release path is symmetric.
- Hold counter, width clog2(LONG_PRESS_CYCLES)+1:
  - cleared at press acceptance; increments every cycle in PRESSED; frozen in DEB_RELEASE.
  - when it reaches LONG_PRESS_CYCLES: o_long pulses once and o_hold<=1; the counter then saturates and o_long never re-fires in the same press.
- o_pending:
  - set at press acceptance.
  - i_ack=1 while pending clears it at the next edge.
  - Press acceptance and i_ack on the same edge: set wins, pending stays 1.
  - i_ack with pending=0 has no effect.
- o_press and o_release never assert in the same cycle. o_long cannot coincide with o_press.

Decomposition:
- Shared package z16_io_pkg holds:
  - the FSM state enum (2-bit encoding IDLE=0, DEB_PRESS=1, PRESSED=2, DEB_RELEASE=3);
  - default constants SYNC_STAGES_DEF=2, DEBOUNCE_DEF=4, LONG_PRESS_DEF=16.
- One sub-module, z16_sync_chain: a parameterised N-flop synchroniser with synchronous active-low reset. The FSM, counters and pending logic stay in the top.

Test Plan (defaults):
- Reset with button held: i_button=1, i_rst_n=0 for 2 cycles then 1 -> all outputs 0 during reset; o_press pulses exactly once at edge 6 after release; o_count=1, o_pending=1.
- Glitch rejection: i_button high for 3 cycles, then low -> o_level, o_press and o_pending stay 0; o_count unchanged.
- Clean press: 10 cycles high then low -> o_press one cycle at edge 6; o_level high; o_release one cycle 6 edges after the falling input; o_long never asserts.
- Long press: 30 cycles high -> o_long single pulse 16 cycles after o_press; o_hold high from then until o_release; a 2-cycle low bounce mid-hold causes no o_release and no second o_press.
- Handshake: i_ack asserted on the same edge as a second press acceptance -> o_pending stays 1; a later lone i_ack -> o_pending 0 at the next edge; i_ack while 0 -> stays 0.
- Counter wrap: 256 clean presses -> o_count reads 255 after the 255th press, then 0 after the 256th.

Source files
------------

// File: rtl/z16_io_pkg.sv
// Shared definitions for the Z16 button conditioner.
// Holds the conditioner FSM state encoding and the default timing constants
// used as parameter defaults by z16_button_conditioner.
package z16_io_pkg;

  // Two-bit state encoding; the values are fixed so that the state can be
  // read as a raw field from a debug port.
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } btn_state_t;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int DEBOUNCE_DEF    = 4;
  localparam int LONG_PRESS_DEF  = 16;

endpackage

// File: rtl/z16_sync_chain.sv
// N-flop synchroniser for a single asynchronous bit.
// Ports:
//   i_clk   - destination clock
//   i_rst_n - synchronous active-low reset, clears every stage
//   i_d     - asynchronous input
//   o_q     - synchronised output (last stage)
module z16_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], i_d};
    end
  end

  assign o_q = sync_reg[STAGES-1];

endmodule

// File: rtl/z16_button_conditioner.sv
// Push-button conditioner feeding the Z16CPU button input.
// Synchronises and debounces the raw button, then produces a clean level,
// one-cycle press/release/long-press pulses, a hold flag, a sticky pending
// flag cleared by CPU acknowledge, and a wrapping press counter.
// Ports:
//   i_clk     - system clock
//   i_rst_n   - synchronous active-low reset
//   i_button  - raw asynchronous button, active-high
//   i_ack     - CPU acknowledge, clears o_pending
//   o_level   - debounced level
//   o_press   - one-cycle pulse on accepted press
//   o_release - one-cycle pulse on accepted release
//   o_long    - one-cycle pulse after LONG_PRESS_CYCLES in the pressed state
//   o_hold    - high from o_long until release
//   o_pending - sticky press flag
//   o_count   - accepted presses, modulo 2^COUNT_W
module z16_button_conditioner
  import z16_io_pkg::*;
#(
  parameter int SYNC_STAGES       = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_DEF,
  parameter int LONG_PRESS_CYCLES = LONG_PRESS_DEF,
  parameter int COUNT_W           = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_button,
  input  logic               i_ack,
  output logic               o_level,
  output logic               o_press,
  output logic               o_release,
  output logic               o_long,
  output logic               o_hold,
  output logic               o_pending,
  output logic [COUNT_W-1:0] o_count
);

  localparam int DCW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HCW = $clog2(LONG_PRESS_CYCLES) + 1;
  localparam logic [DCW-1:0]     DEB_ONE   = DCW'(1);
  localparam logic [DCW-1:0]     DEB_LAST  = DCW'(DEBOUNCE_CYCLES);
  localparam logic [HCW-1:0]     HOLD_ONE  = HCW'(1);
  localparam logic [HCW-1:0]     HOLD_LAST = HCW'(LONG_PRESS_CYCLES);
  localparam logic [COUNT_W-1:0] CNT_ONE   = COUNT_W'(1);

  logic s;

  z16_sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_button),
    .o_q     (s)
  );

  btn_state_t         state_reg,   state_next;
  logic [DCW-1:0]     deb_cnt_reg, deb_cnt_next;
  logic [HCW-1:0]     hold_cnt_reg, hold_cnt_next;
  logic               level_reg,   level_next;
  logic               press_reg,   press_next;
  logic               release_reg, release_next;
  logic               long_reg,    long_next;
  logic               hold_reg,    hold_next;
  logic               pending_reg, pending_next;
  logic [COUNT_W-1:0] count_reg,   count_next;
  logic [DCW-1:0]     deb_inc;
  logic [HCW-1:0]     hold_inc;

  assign deb_inc  = deb_cnt_reg + DEB_ONE;
  assign hold_inc = hold_cnt_reg + HOLD_ONE;

  always_comb begin
    state_next    = state_reg;
    deb_cnt_next  = deb_cnt_reg;
    hold_cnt_next = hold_cnt_reg;
    level_next    = level_reg;
    press_next    = 1'b0;
    release_next  = 1'b0;
    long_next     = 1'b0;
    hold_next     = hold_reg;
    count_next    = count_reg;
    // Ack clears first; a press accepted on the same edge overrides below.
    pending_next  = i_ack ? 1'b0 : pending_reg;

    case (state_reg)
      IDLE: begin
        if (s) begin
          state_next   = DEB_PRESS;
          deb_cnt_next = DEB_ONE;
        end
      end
      DEB_PRESS: begin
        if (!s) begin
          state_next = IDLE;
        end else if (deb_inc == DEB_LAST) begin
          state_next    = PRESSED;
          level_next    = 1'b1;
          press_next    = 1'b1;
          count_next    = count_reg + CNT_ONE;
          pending_next  = 1'b1;
          hold_cnt_next = '0;
        end else begin
          deb_cnt_next = deb_inc;
        end
      end
      PRESSED: begin
        // Saturating hold counter: o_long fires only on the step that
        // reaches the threshold, so it cannot repeat within one press.
        if (hold_cnt_reg != HOLD_LAST) begin
          hold_cnt_next = hold_inc;
          if (hold_inc == HOLD_LAST) begin
            long_next = 1'b1;
            hold_next = 1'b1;
          end
        end
        if (!s) begin
          state_next   = DEB_RELEASE;
          deb_cnt_next = DEB_ONE;
        end
      end
      DEB_RELEASE: begin
        if (s) begin
          state_next = PRESSED;
        end else if (deb_inc == DEB_LAST) begin
          state_next    = IDLE;
          level_next    = 1'b0;
          release_next  = 1'b1;
          hold_next     = 1'b0;
          hold_cnt_next = '0;
        end else begin
          deb_cnt_next = deb_inc;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg    <= IDLE;
      deb_cnt_reg  <= '0;
      hold_cnt_reg <= '0;
      level_reg    <= 1'b0;
      press_reg    <= 1'b0;
      release_reg  <= 1'b0;
      long_reg     <= 1'b0;
      hold_reg     <= 1'b0;
      pending_reg  <= 1'b0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      deb_cnt_reg  <= deb_cnt_next;
      hold_cnt_reg <= hold_cnt_next;
      level_reg    <= level_next;
      press_reg    <= press_next;
      release_reg  <= release_next;
      long_reg     <= long_next;
      hold_reg     <= hold_next;
      pending_reg  <= pending_next;
      count_reg    <= count_next;
    end
  end

  assign o_level   = level_reg;
  assign o_press   = press_reg;
  assign o_release = release_reg;
  assign o_long    = long_reg;
  assign o_hold    = hold_reg;
  assign o_pending = pending_reg;
  assign o_count   = count_reg;

endmodule

// File: tb/tb_z16_button_conditioner.sv
// Directed testbench for z16_button_conditioner with default parameters.
// Inputs change 1 time unit after a rising edge; outputs are observed at
// the same point, so "after edge k" is what each check sees.
module tb_z16_button_conditioner;

  logic       i_clk    = 1'b0;
  logic       i_rst_n  = 1'b0;
  logic       i_button = 1'b0;
  logic       i_ack    = 1'b0;
  logic       o_level;
  logic       o_press;
  logic       o_release;
  logic       o_long;
  logic       o_hold;
  logic       o_pending;
  logic [7:0] o_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0] exp_flags;
  logic [5:0] got_flags;
  logic [7:0] exp_count;

  z16_button_conditioner dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_button  (i_button),
    .i_ack     (i_ack),
    .o_level   (o_level),
    .o_press   (o_press),
    .o_release (o_release),
    .o_long    (o_long),
    .o_hold    (o_hold),
    .o_pending (o_pending),
    .o_count   (o_count)
  );

  always #5 i_clk = ~i_clk;

  assign got_flags = {o_level, o_press, o_release, o_long, o_hold, o_pending};

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  // Flags are {level, press, release, long, hold, pending}.
  task automatic test_reset;
    i_button = 1'b1;
    i_rst_n  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (got_flags !== 6'b0 || o_count !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_state cyc=%0d got flags=%b count=%0d want flags=000000 count=0", i, got_flags, o_count);
      end
    end
    i_rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_flags = {k >= 6, k == 6, 1'b0, 1'b0, 1'b0, k >= 6};
      exp_count = (k >= 6) ? 8'd1 : 8'd0;
      n_checks++;
      if (got_flags !== exp_flags || o_count !== exp_count) begin
        n_fail++;
        $display("FAIL reset_held_press edge=%0d got flags=%b count=%0d want flags=%b count=%0d", k, got_flags, o_count, exp_flags, exp_count);
      end
    end
    i_button = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_flags = {k < 6, 1'b0, k == 6, 1'b0, 1'b0, 1'b1};
      n_checks++;
      if (got_flags !== exp_flags) begin
        n_fail++;
        $display("FAIL reset_release edge=%0d got flags=%b want flags=%b", k, got_flags, exp_flags);
      end
    end
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    n_checks++;
    if (o_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ack got pending=%b want 0", o_pending);
    end
    $display("test_reset done");
  endtask

  task automatic test_glitch;
    for (int k = 1; k <= 12; k++) begin
      i_button = (k <= 3);
      tick();
      n_checks++;
      if (got_flags !== 6'b0 || o_count !== 8'd1) begin
        n_fail++;
        $display("FAIL glitch edge=%0d got flags=%b count=%0d want flags=000000 count=1", k, got_flags, o_count);
      end
    end
    $display("test_glitch done");
  endtask

  task automatic test_clean_press;
    for (int k = 1; k <= 20; k++) begin
      i_button = (k <= 10);
      tick();
      exp_flags = {k >= 6 && k < 16, k == 6, k == 16, 1'b0, 1'b0, k >= 6};
      exp_count = (k >= 6) ? 8'd2 : 8'd1;
      n_checks++;
      if (got_flags !== exp_flags || o_count !== exp_count) begin
        n_fail++;
        $display("FAIL clean_press edge=%0d got flags=%b count=%0d want flags=%b count=%0d", k, got_flags, o_count, exp_flags, exp_count);
      end
    end
    $display("test_clean_press done");
  endtask

  // Held input with a 2-cycle low bounce at edges 25-26, released at 35.
  task automatic test_long_press;
    for (int k = 1; k <= 45; k++) begin
      i_button = (k <= 34) && !(k == 25 || k == 26);
      tick();
      exp_flags = {k >= 6 && k < 40, k == 6, k == 40, k == 22, k >= 22 && k < 40, 1'b1};
      exp_count = (k >= 6) ? 8'd3 : 8'd2;
      n_checks++;
      if (got_flags !== exp_flags || o_count !== exp_count) begin
        n_fail++;
        $display("FAIL long_press edge=%0d got flags=%b count=%0d want flags=%b count=%0d", k, got_flags, o_count, exp_flags, exp_count);
      end
    end
    $display("test_long_press done");
  endtask

  task automatic test_handshake;
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    n_checks++;
    if (o_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_clear got pending=%b want 0", o_pending);
    end
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    n_checks++;
    if (o_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_idle got pending=%b want 0", o_pending);
    end
    for (int k = 1; k <= 20; k++) begin
      i_button = (k <= 10);
      i_ack    = (k == 6);
      tick();
      exp_count = (k >= 6) ? 8'd4 : 8'd3;
      n_checks++;
      if (o_pending !== (k >= 6) || o_press !== (k == 6) || o_count !== exp_count) begin
        n_fail++;
        $display("FAIL ack_same_edge edge=%0d got pending=%b press=%b count=%0d want pending=%b press=%b count=%0d",
                 k, o_pending, o_press, o_count, k >= 6, k == 6, exp_count);
      end
    end
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    n_checks++;
    if (o_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_lone got pending=%b want 0", o_pending);
    end
    tick();
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    n_checks++;
    if (o_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_while_clear got pending=%b want 0", o_pending);
    end
    $display("test_handshake done");
  endtask

  task automatic test_count_wrap;
    i_button = 1'b0;
    i_rst_n  = 1'b0;
    tick();
    i_rst_n = 1'b1;
    n_checks++;
    if (o_count !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap_reset got count=%0d want 0", o_count);
    end
    exp_count = 8'd0;
    for (int p = 0; p < 256; p++) begin
      for (int k = 1; k <= 16; k++) begin
        i_button = (k <= 8);
        tick();
      end
      exp_count = exp_count + 8'd1;
      n_checks++;
      if (o_count !== exp_count) begin
        n_fail++;
        $display("FAIL wrap_step press=%0d got count=%0d want %0d", p + 1, o_count, exp_count);
      end
      if (p == 254) begin
        n_checks++;
        if (o_count !== 8'd255) begin
          n_fail++;
          $display("FAIL wrap_255 got count=%0d want 255", o_count);
        end
      end
      if (p == 255) begin
        n_checks++;
        if (o_count !== 8'd0) begin
          n_fail++;
          $display("FAIL wrap_0 got count=%0d want 0", o_count);
        end
      end
    end
    $display("test_count_wrap done");
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_clean_press();
    test_long_press();
    test_handshake();
    test_count_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
